// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES (Inv)ShiftRows stage: gathers 16 bytes, emits one 128-bit state.
// One finished block is held at the output while the next block is collected.
module inv_shift_rows_stream #(
    parameter bit INVERSE    = 1'b1,
    parameter bit CHECK_LAST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         err,
    output logic         busy
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   buf_q, buf_d;
    logic [127:0]   out_state_q, out_state_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;

    logic           accept;
    logic           slot_free;
    logic           xfer;
    logic           full_byte;
    logic           frame_drop;
    logic           load;

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [31:0] r1, r2, r3;
        r1 = s[63:32];
        r2 = s[95:64];
        r3 = s[127:96];
        if (INVERSE) begin
            return {r3[7:0], r3[31:8], r2[15:0], r2[31:16],
                    r1[23:0], r1[31:24], s[31:0]};
        end
        return {r3[23:0], r3[31:24], r2[15:0], r2[31:16],
                r1[7:0], r1[31:8], s[31:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = COLLECT;
        end else begin
            unique case (state_q)
                COLLECT: if (full_byte && !slot_free) state_d = PENDING;
                PENDING: if (slot_free) state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == COLLECT) && !abort && !rst;
        busy     = (cnt_q != 4'd0) || (state_q == PENDING);
    end

    always_comb begin
        accept     = in_valid && in_ready;
        slot_free  = !out_valid_q || out_ready;
        xfer       = out_valid_q && out_ready;
        full_byte  = accept && (cnt_q == 4'd15);
        frame_drop = CHECK_LAST && accept && in_last && (cnt_q != 4'd15);

        // In PENDING no byte is accepted, so buf_d is the completed block.
        buf_d = buf_q;
        if (accept && !frame_drop) begin
            buf_d[{cnt_q, 3'b000} +: 8] = in_byte;
        end

        load = !abort && slot_free &&
               (((state_q == COLLECT) && full_byte) || (state_q == PENDING));

        cnt_d = cnt_q;
        if (abort || frame_drop || load) begin
            cnt_d = 4'd0;
        end else if (accept && !full_byte) begin
            cnt_d = cnt_q + 4'd1;
        end

        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_state_d = shift_rows(buf_d);
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end

        err_d = frame_drop || (CHECK_LAST && full_byte && !in_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            buf_q       <= '0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_state = out_state_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed bench: inverse and forward instances share one stimulus stream.
// Expected states are hand-computed constants.
module tb_inv_shift_rows_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         abort;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         out_ready;

    logic         in_ready_i, out_valid_i, err_i, busy_i;
    logic [127:0] out_state_i;
    logic         in_ready_f, out_valid_f, err_f, busy_f;
    logic [127:0] out_state_f;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    inv_shift_rows_stream #(.INVERSE(1'b1), .CHECK_LAST(1'b1)) u_inv (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_i),
        .in_byte(in_byte), .in_last(in_last),
        .out_valid(out_valid_i), .out_ready(out_ready),
        .out_state(out_state_i), .err(err_i), .busy(busy_i)
    );

    inv_shift_rows_stream #(.INVERSE(1'b0), .CHECK_LAST(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready_f),
        .in_byte(in_byte), .in_last(in_last),
        .out_valid(out_valid_f), .out_ready(out_ready),
        .out_state(out_state_f), .err(err_f), .busy(busy_f)
    );

    typedef struct {
        logic [127:0] in_blk;
        logic [127:0] exp_inv;
        logic [127:0] exp_fwd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic put_byte(input logic [7:0] b, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        #1;
        while (!in_ready_i && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        stalls += n;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL put_byte: in_ready stuck 0 for %0d cycles", n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_block(input logic [127:0] b, input int last_at);
        for (int i = 0; i < 16; i++) begin
            put_byte(b[8*i +: 8], (i == last_at));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        logic       bad;
        logic [127:0] hold;

        vecs[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    128'h0C0F0E0D_09080B0A_06050407_03020100,
                    128'h0E0D0C0F_09080B0A_04070605_03020100};
        vecs[1] = '{128'h1F1E1D1C_1B1A1918_17161514_13121110,
                    128'h1C1F1E1D_19181B1A_16151417_13121110,
                    128'h1E1D1C1F_19181B1A_14171615_13121110};
        vecs[2] = '{128'hFFEEDDCC_BBAA9988_77665544_33221100,
                    128'hCCFFEEDD_9988BBAA_66554477_33221100,
                    128'hEEDDCCFF_9988BBAA_44776655_33221100};
        vecs[3] = '{128'h00000000_00000000_0000AA00_00000000,
                    128'h00000000_00000000_00AA0000_00000000,
                    128'h00000000_00000000_000000AA_00000000};
        vecs[4] = '{128'h0E0D0C0F_09080B0A_04070605_03020100,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100,
                    128'h0D0C0F0E_0B0A0908_05040706_03020100};

        rst = 1'b1; abort = 1'b0; in_valid = 1'b0;
        in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {127'd0, out_valid_i}, 128'd0);
        chk("rst_out_state", out_state_i, 128'd0);
        chk("rst_err",       {127'd0, err_i}, 128'd0);
        chk("rst_busy",      {127'd0, busy_i}, 128'd0);
        chk("rst_in_ready",  {127'd0, in_ready_i}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {127'd0, in_ready_i}, 128'd1);

        for (int v = 0; v < 5; v++) begin
            send_block(vecs[v].in_blk, 15);
            chk($sformatf("vec%0d_valid", v), {127'd0, out_valid_i}, 128'd1);
            chk($sformatf("vec%0d_inv", v), out_state_i, vecs[v].exp_inv);
            chk($sformatf("vec%0d_fwd", v), out_state_f, vecs[v].exp_fwd);
            chk($sformatf("vec%0d_err", v), {127'd0, err_i}, 128'd0);
        end
        chk("no_stalls", 128'(stalls), 128'd0);
        @(negedge clk);
        chk("drain_valid", {127'd0, out_valid_i}, 128'd0);

        // Back-pressure: block A held, block B parks in PENDING.
        out_ready = 1'b0;
        send_block(vecs[0].in_blk, 15);
        chk("bp_a_valid", {127'd0, out_valid_i}, 128'd1);
        send_block(vecs[2].in_blk, 15);
        #1;
        chk("bp_pend_in_ready", {127'd0, in_ready_i}, 128'd0);
        chk("bp_pend_busy", {127'd0, busy_i}, 128'd1);
        bad = 1'b0;
        hold = vecs[0].exp_inv;
        repeat (40) begin
            @(negedge clk);
            if (out_state_i !== hold || out_valid_i !== 1'b1 ||
                in_ready_i !== 1'b0) bad = 1'b1;
        end
        chk("bp_stable", {127'd0, bad}, 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_valid", {127'd0, out_valid_i}, 128'd1);
        chk("bp_b_inv", out_state_i, vecs[2].exp_inv);
        chk("bp_b_fwd", out_state_f, vecs[2].exp_fwd);
        @(negedge clk);
        chk("bp_drain", {127'd0, out_valid_i}, 128'd0);
        chk("bp_busy", {127'd0, busy_i}, 128'd0);

        // Early in_last on byte 5.
        for (int i = 0; i < 6; i++) put_byte(8'h50 + 8'(i), (i == 5));
        in_valid = 1'b0; in_last = 1'b0;
        chk("early_last_err", {127'd0, err_i}, 128'd1);
        chk("early_last_busy", {127'd0, busy_i}, 128'd0);
        chk("early_last_novalid", {127'd0, out_valid_i}, 128'd0);
        @(negedge clk);
        chk("early_last_err_pulse", {127'd0, err_i}, 128'd0);
        send_block(vecs[1].in_blk, 15);
        chk("after_err_inv", out_state_i, vecs[1].exp_inv);

        // Missing in_last on byte 15.
        send_block(vecs[2].in_blk, -1);
        chk("no_last_valid", {127'd0, out_valid_i}, 128'd1);
        chk("no_last_inv", out_state_i, vecs[2].exp_inv);
        chk("no_last_err", {127'd0, err_i}, 128'd1);
        @(negedge clk);
        chk("no_last_err_pulse", {127'd0, err_i}, 128'd0);

        // Abort after 9 bytes, with a byte offered alongside.
        for (int i = 0; i < 9; i++) put_byte(8'hC0 + 8'(i), 1'b0);
        abort = 1'b1;
        #1;
        chk("abort_in_ready", {127'd0, in_ready_i}, 128'd0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {127'd0, busy_i}, 128'd0);
        chk("abort_novalid", {127'd0, out_valid_i}, 128'd0);
        send_block(vecs[3].in_blk, 15);
        chk("after_abort_inv", out_state_i, vecs[3].exp_inv);
        chk("after_abort_fwd", out_state_f, vecs[3].exp_fwd);

        // Abort while PENDING.
        @(negedge clk);
        out_ready = 1'b0;
        send_block(vecs[0].in_blk, 15);
        send_block(vecs[2].in_blk, 15);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pend_busy", {127'd0, busy_i}, 128'd0);
        chk("abort_pend_novalid", {127'd0, out_valid_i}, 128'd0);
        send_block(vecs[1].in_blk, 15);
        chk("after_pabort_inv", out_state_i, vecs[1].exp_inv);

        // Reset mid-block.
        @(negedge clk);
        for (int i = 0; i < 7; i++) put_byte(8'hE0 + 8'(i), 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {127'd0, busy_i}, 128'd0);
        chk("rst_mid_state", out_state_i, 128'd0);
        send_block(vecs[2].in_blk, 15);
        chk("after_rst_inv", out_state_i, vecs[2].exp_inv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

endmodule
